// File: rtl/type_pkg.sv
// Shared definitions for the typing engine: character width, character codes
// and the FSM state encoding.
package type_pkg;

  localparam int unsigned CW = 5;

  localparam logic [CW-1:0] CODE_EMPTY = 5'd0;
  localparam logic [CW-1:0] CODE_A     = 5'd1;
  localparam logic [CW-1:0] CODE_Z     = 5'd26;
  localparam logic [CW-1:0] CODE_SPACE = 5'd27;

  localparam int unsigned ST_W = 2;
  localparam logic [ST_W-1:0] ST_IDLE   = 2'd0;
  localparam logic [ST_W-1:0] ST_TYPING = 2'd1;
  localparam logic [ST_W-1:0] ST_DONE   = 2'd2;

endpackage

// File: rtl/char_match.sv
// Single-slot comparator: a slot is correct when it is filled and its code
// equals the target code for that position.
//   slot    in  typed code for this slot
//   tgt     in  target code for this slot
//   filled  in  slot index is below the fill count
//   match_c out combinational match flag
module char_match #(
  parameter int unsigned W = type_pkg::CW
) (
  input  logic [W-1:0] slot,
  input  logic [W-1:0] tgt,
  input  logic         filled,
  output logic         match_c
);

  assign match_c = filled && (slot == tgt);

endmodule

// File: rtl/type_buffer.sv
// Typing engine: accepts decoded key events, keeps the typed-character array,
// per-slot correctness bitmap and fill count, and flags sentence completion.
// Optional wrong-keystroke counter enabled by defining TYPE_BUF_ERRCNT_EN.
//   clk, rst (async, active-low)
//   key_valid/key_ready  key event handshake; key_bs selects backspace
//   key_code             character code (0 is ignored)
//   clr                  synchronous clear of buffer and FSM
//   target               target sentence, slot i at [CW*i +: CW]
//   typed                typed characters, same packing ("type" is a keyword)
//   correct, tot, full   per-slot match bitmap, fill count, buffer full
//   start                one-cycle pulse on first accepted character
//   done                 sentence completed correctly (held until clr)
//   err_cnt              saturating wrong-keystroke count (0 when disabled)
module type_buffer #(
  parameter int unsigned N  = 25,
  parameter int unsigned CW = type_pkg::CW,
  parameter int unsigned TW = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            key_valid,
  output logic            key_ready,
  input  logic            key_bs,
  input  logic [CW-1:0]   key_code,
  input  logic            clr,
  input  logic [N*CW-1:0] target,
  output logic [N*CW-1:0] typed,
  output logic [N-1:0]    correct,
  output logic [TW-1:0]   tot,
  output logic            full,
  output logic            start,
  output logic            done,
  output logic [7:0]      err_cnt
);

  import type_pkg::*;

  localparam int unsigned ERR_W = 8;

  logic [ST_W-1:0] state_q, state_d;
  logic [N*CW-1:0] type_q, type_d;
  logic [TW-1:0]   tot_q, tot_d;
  logic [N-1:0]    correct_q, match_c;
  logic            full_q, start_q, start_d, done_q, key_ready_q;
  logic            accept_c, char_wr_c, complete_c;

  assign accept_c = key_valid && key_ready_q;

  // Buffer update: character append, backspace, clear.
  always_comb begin
    type_d    = type_q;
    tot_d     = tot_q;
    char_wr_c = 1'b0;
    if (clr) begin
      type_d = '0;
      tot_d  = '0;
    end else if (accept_c) begin
      if (key_bs) begin
        if (tot_q != '0) begin
          for (int i = 0; i < int'(N); i++) begin
            if (TW'(i) == tot_q - TW'(1)) type_d[i*CW +: CW] = '0;
          end
          tot_d = tot_q - TW'(1);
        end
      end else if ((key_code != '0) && (tot_q < TW'(N))) begin
        for (int i = 0; i < int'(N); i++) begin
          if (TW'(i) == tot_q) type_d[i*CW +: CW] = key_code;
        end
        tot_d     = tot_q + TW'(1);
        char_wr_c = 1'b1;
      end
    end
  end

  // Per-slot correctness against the post-update buffer.
  for (genvar g = 0; g < int'(N); g++) begin : g_match
    char_match #(.W(CW)) u_match (
      .slot    (type_d[g*CW +: CW]),
      .tgt     (target[g*CW +: CW]),
      .filled  (TW'(g) < tot_d),
      .match_c (match_c[g])
    );
  end

  assign complete_c = (tot_d == TW'(N)) && (&match_c);

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    start_d = 1'b0;
    if (clr) begin
      state_d = ST_IDLE;
    end else begin
      if (char_wr_c && (state_q == ST_IDLE)) begin
        state_d = ST_TYPING;
        start_d = 1'b1;
      end
      if ((state_d == ST_TYPING) && complete_c) state_d = ST_DONE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      type_q      <= '0;
      tot_q       <= '0;
      correct_q   <= '0;
      full_q      <= 1'b0;
      start_q     <= 1'b0;
      done_q      <= 1'b0;
      key_ready_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      type_q      <= type_d;
      tot_q       <= tot_d;
      correct_q   <= match_c;
      full_q      <= (tot_d == TW'(N));
      start_q     <= start_d;
      done_q      <= (state_d == ST_DONE);
      key_ready_q <= (state_d != ST_DONE);
    end
  end

`ifdef TYPE_BUF_ERRCNT_EN
  logic [CW-1:0]    cur_tgt_c;
  logic [ERR_W-1:0] err_q, err_d;

  // Target code of the slot about to be written.
  always_comb begin
    cur_tgt_c = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (TW'(i) == tot_q) cur_tgt_c = target[i*CW +: CW];
    end
  end

  always_comb begin
    err_d = err_q;
    if (clr) begin
      err_d = '0;
    end else if (char_wr_c && (key_code != cur_tgt_c) && (err_q != {ERR_W{1'b1}})) begin
      err_d = err_q + ERR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) err_q <= '0;
    else      err_q <= err_d;
  end

  assign err_cnt = err_q;
`else
  assign err_cnt = '0;
`endif

  assign key_ready = key_ready_q;
  assign typed     = type_q;
  assign correct   = correct_q;
  assign tot       = tot_q;
  assign full      = full_q;
  assign start     = start_q;
  assign done      = done_q;

endmodule
